// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall controller.
// The controller connects through the slave modport; the pipeline (or bench) uses master.
interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic                 ex_mem_read;
    logic [4:0]           ex_rd;
    logic                 ex_redirect;
    logic                 imem_ready;
    logic                 mem_req;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 ifid_write;
    logic                 ifid_flush;
    logic                 idex_write;
    logic                 idex_flush;
    logic                 exmem_write;
    logic                 timeout_err;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] redirect_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               ex_redirect, imem_ready, mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, timeout_err, stall_cycles, redirect_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               ex_redirect, imem_ready, mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, timeout_err, stall_cycles, redirect_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage RV32I pipeline: load-use, redirect,
// fetch-wait and data-wait handling, a data-memory watchdog and two performance counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [WAIT_W-1:0]    r_waitCnt;
    logic [WAIT_W-1:0]    w_waitNext;
    logic [WAIT_W-1:0]    w_waitInc;
    logic [CNT_WIDTH-1:0] r_stallCnt;
    logic [CNT_WIDTH-1:0] r_redirCnt;
    logic                 w_lu;
    logic                 w_runRedir;
    logic                 w_redirTaken;
    // Control vectors are ordered {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}
    logic [5:0]           w_runCtl;
    logic [5:0]           w_ctl;

    assign w_lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                  ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                   (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

    assign w_waitInc = (r_waitCnt == '1) ? r_waitCnt : r_waitCnt + WAIT_W'(1);

    // Decision used whenever no data access is holding MEM
    always_comb begin
        w_runRedir = 1'b0;
        w_runCtl   = 6'b110101;
        if (bus.ex_redirect) begin
            w_runCtl   = 6'b111111;
            w_runRedir = 1'b1;
        end else if (w_lu) begin
            w_runCtl = 6'b000111;
        end else if (!bus.imem_ready) begin
            w_runCtl = 6'b011101;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_waitNext   = r_waitCnt;
        w_ctl        = 6'b000000;
        w_redirTaken = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    w_waitNext  = WAIT_W'(1);
                    w_stateNext = (MEM_TIMEOUT == 1) ? FAULT : MEM_WAIT;
                end else begin
                    w_ctl        = w_runCtl;
                    w_redirTaken = w_runRedir;
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ready) begin
                    w_waitNext = w_waitInc;
                    if ((MEM_TIMEOUT != 0) && (w_waitInc == WAIT_LIMIT)) begin
                        w_stateNext = FAULT;
                    end
                end else begin
                    w_ctl        = w_runCtl;
                    w_redirTaken = w_runRedir;
                    w_stateNext  = RUN;
                    w_waitNext   = '0;
                end
            end
            FAULT: begin
                w_stateNext = FAULT;
            end
            default: begin
                w_stateNext = RUN;
                w_waitNext  = '0;
            end
        endcase
        if (rst) begin
            w_ctl        = 6'b000000;
            w_redirTaken = 1'b0;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitNext;
        end
    end

    // Stall cycles are any cycle the PC holds, FAULT included
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_redirCnt <= '0;
        end else begin
            if (!w_ctl[5]) begin
                r_stallCnt <= r_stallCnt + CNT_WIDTH'(1);
            end
            if (w_redirTaken) begin
                r_redirCnt <= r_redirCnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.pc_write       = w_ctl[5];
    assign bus.ifid_write     = w_ctl[4];
    assign bus.ifid_flush     = w_ctl[3];
    assign bus.idex_write     = w_ctl[2];
    assign bus.idex_flush     = w_ctl[1];
    assign bus.exmem_write    = w_ctl[0];
    assign bus.timeout_err    = (r_state == FAULT);
    assign bus.stall_cycles   = r_stallCnt;
    assign bus.redirect_count = r_redirCnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl, checked against a cycle-level
// behavioural model of the stall rules (watchdog limit 4, 4-bit counters).
module tb_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CW      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_ctrl_if #(.CNT_WIDTH(CW)) hif ();

    hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    bit faulted   = 1'b0;
    int waitCycles = 0;
    int modelStall = 0;
    int modelRedir = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic memRead,
                                 input logic [4:0] rd, input logic redir, input logic imem,
                                 input logic req, input logic ready);
        hif.id_rs1      = rs1;
        hif.id_rs2      = rs2;
        hif.id_uses_rs1 = u1;
        hif.id_uses_rs2 = u2;
        hif.ex_mem_read = memRead;
        hif.ex_rd       = rd;
        hif.ex_redirect = redir;
        hif.imem_ready  = imem;
        hif.mem_req     = req;
        hif.mem_ready   = ready;
    endtask

    // Expected enables, bit order {pc, ifid_w, ifid_f, idex_w, idex_f, exmem_w}, plus redirect flag on top
    function automatic logic [6:0] modelDecide();
        logic       hazard;
        logic       busy;
        logic [5:0] c;
        logic       r;
        c = 6'b000000;
        r = 1'b0;
        hazard = hif.ex_mem_read && (hif.ex_rd != 5'd0) &&
                 ((hif.id_uses_rs1 && hif.id_rs1 == hif.ex_rd) ||
                  (hif.id_uses_rs2 && hif.id_rs2 == hif.ex_rd));
        busy = ((waitCycles > 0) || hif.mem_req) && !hif.mem_ready;
        if (rst || faulted || busy) begin
            c = 6'b000000;
        end else if (hif.ex_redirect) begin
            c = 6'b111111;
            r = 1'b1;
        end else if (hazard) begin
            c = 6'b000111;
        end else if (!hif.imem_ready) begin
            c = 6'b011101;
        end else begin
            c = 6'b110101;
        end
        return {r, c};
    endfunction

    // Compare all outputs, then advance the model by the coming falling edge
    task automatic checkOutput(input string tag);
        logic [6:0] e;
        #1;
        e = modelDecide();
        check({tag, ".pc_write"},    32'(hif.pc_write),    32'(e[5]));
        check({tag, ".ifid_write"},  32'(hif.ifid_write),  32'(e[4]));
        check({tag, ".ifid_flush"},  32'(hif.ifid_flush),  32'(e[3]));
        check({tag, ".idex_write"},  32'(hif.idex_write),  32'(e[2]));
        check({tag, ".idex_flush"},  32'(hif.idex_flush),  32'(e[1]));
        check({tag, ".exmem_write"}, 32'(hif.exmem_write), 32'(e[0]));
        check({tag, ".timeout_err"}, 32'(hif.timeout_err), 32'(faulted && !rst));
        check({tag, ".stall_cycles"},   32'(hif.stall_cycles),   32'(modelStall));
        check({tag, ".redirect_count"}, 32'(hif.redirect_count), 32'(modelRedir));
        if (!rst) begin
            if (!e[5]) modelStall = (modelStall + 1) % (1 << CW);
            if (e[6])  modelRedir = (modelRedir + 1) % (1 << CW);
            if (!faulted) begin
                if (((waitCycles > 0) || hif.mem_req) && !hif.mem_ready) begin
                    waitCycles++;
                    if (waitCycles == TIMEOUT) faulted = 1'b1;
                end else begin
                    waitCycles = 0;
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic memRead,
                        input logic [4:0] rd, input logic redir, input logic imem,
                        input logic req, input logic ready);
        applyStimulus(rs1, rs2, u1, u2, memRead, rd, redir, imem, req, ready);
        checkOutput(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic resetPulse(input string tag);
        rst        = 1'b1;
        faulted    = 1'b0;
        waitCycles = 0;
        modelStall = 0;
        modelRedir = 0;
        checkOutput(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        resetPulse("reset");
        idle("idle0");

        step("loaduse", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        idle("loaduse_after");
        check("loaduse_stall_total", 32'(hif.stall_cycles), 32'd1);
        step("loaduse_x0", 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("loaduse_rs2", 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1);
        step("loaduse_unused", 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1);

        step("redir_hazard", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        idle("redir_after");

        for (int i = 0; i < 3; i++) begin
            step("memwait", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        step("memwait_done", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle("memwait_after");

        for (int i = 0; i < 2; i++) begin
            step("fetchwait", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        for (int i = 0; i < 2; i++) begin
            step("wait_redir", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        step("wait_redir_done", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle("wait_redir_after");

        resetPulse("wd_reset");
        for (int i = 0; i < TIMEOUT; i++) begin
            step("watchdog", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        check("watchdog_err", 32'(hif.timeout_err), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step("fault_hold", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        resetPulse("fault_reset");
        check("fault_reset_err", 32'(hif.timeout_err), 32'd0);
        idle("fault_reset_idle");

        resetPulse("wrap_reset");
        for (int i = 0; i < 17; i++) begin
            step("wrap", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        check("wrap_count", 32'(hif.redirect_count), 32'd1);

        for (int i = 0; i < 400; i++) begin
            if ((faulted && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 99) == 0)) begin
                resetPulse("rand_reset");
            end else begin
                step("rand",
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) != 0),
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) < 6));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the RV32I five-stage core. Each cycle it decides whether the PC, the IF/ID register, the ID/EX register and the EX/MEM register advance, hold or take a bubble. It detects load-use hazards, EX-stage control-flow redirects, instruction-fetch waits and data-memory waits. It also keeps a data-memory timeout watchdog and two performance counters.

## Interface
- MEM_TIMEOUT, default 255: maximum consecutive MEM_WAIT cycles before a fault; 0 disables the watchdog.
- CNT_WIDTH, default 32: width of the performance counters.
- clk  in  1  clock; all state updates on the falling edge, the same edge on which the pipeline registers capture.
- rst  in  1  reset, asynchronous, active-high.
- id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_redirect  in  1  branch taken or jump resolved in EX; the PC mux selects the target.
- imem_ready  in  1  the instruction word presented to IF/ID this cycle is valid.
- mem_req  in  1  the instruction in MEM performs a data access.
- mem_ready  in  1  the data access completes this cycle.
- pc_write  out  1  PC loads the next value.
- ifid_write  out  1  IF/ID captures.
- ifid_flush  out  1  IF/ID captures instruction 0. Only effective together with ifid_write=1.
- idex_write  out  1  ID/EX captures.
- idex_flush  out  1  ID/EX captures a bubble (all control fields 0).
- exmem_write  out  1  EX/MEM captures; the MEM/WB register is frozen by the same signal.
- timeout_err  out  1  sticky watchdog fault.
- stall_cycles  out  CNT_WIDTH  number of cycles with pc_write=0.
- redirect_count  out  CNT_WIDTH  number of redirects accepted.

## Operation
- The FSM has three states: RUN, MEM_WAIT and FAULT. Reset state is RUN.
- Outputs are a combinational function of the state and the current inputs.
- Load-use hazard: lu = ex_mem_read & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- In RUN, the first matching condition in this priority list sets the outputs:
  1. mem_req & !mem_ready (freeze): all write enables 0, all flushes 0. The FSM moves to MEM_WAIT.
  2. ex_redirect: pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_flush=1, exmem_write=1. The redirect overrides lu and !imem_ready.
  3. lu: pc_write=0, ifid_write=0, idex_write=1, idex_flush=1, exmem_write=1.
  4. !imem_ready: pc_write=0, ifid_write=1, ifid_flush=1, idex_write=1, idex_flush=0, exmem_write=1.
  5. Otherwise all write enables are 1 and all flushes are 0.
- MEM_WAIT:
  - Freeze outputs are held while mem_ready=0, and the wait counter increments each cycle.
  - When mem_ready=1, the cycle's outputs are evaluated exactly as in RUN with condition 1 false. The FSM returns to RUN and the wait counter clears.
  - If MEM_TIMEOUT≠0 and the wait counter reaches MEM_TIMEOUT while mem_ready=0, the FSM moves to FAULT.
- FAULT: all write enables 0 and all flushes 0; timeout_err=1. Only rst leaves FAULT.
- The wait counter is ceil(log2(MEM_TIMEOUT+1)) bits wide and saturates; it never wraps.
- stall_cycles increments in every cycle with pc_write=0, including FAULT.
- redirect_count increments in every cycle in which priority 2 is taken.
- Both performance counters wrap modulo 2^CNT_WIDTH.

## Timing
- Outputs have zero-cycle latency: an input change is reflected in the same cycle, before the falling edge.
- State and counters update on the falling edge.
- A load-use stall lasts exactly one cycle. On the next edge the load moves to MEM, ex_mem_read drops and lu clears.
- A data-memory wait of N cycles (mem_ready rising on the N-th cycle) freezes the pipeline for N-1 edges.
- A redirect that coincides with a pending data wait takes effect only on the cycle with mem_ready=1. EX is frozen during the wait, so ex_redirect stays asserted until then.
- Reset values:
  - state RUN; wait counter 0; stall_cycles 0; redirect_count 0; timeout_err 0.
  - While rst=1: pc_write, ifid_write, idex_write and exmem_write are forced to 0, and ifid_flush and idex_flush are forced to 0.
- rst asserted in MEM_WAIT or FAULT takes effect immediately; no counter keeps a value across reset.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1; stall_cycles increases by 1. The same stimulus with ex_rd=0 -> no stall.
- Redirect plus hazard: ex_redirect=1 together with lu=1 and imem_ready=0 -> ifid_flush=1, idex_flush=1, pc_write=1; redirect_count increases by 1.
- Memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1 -> 3 cycles with all enables 0; the FSM is back in RUN after the 4th edge; stall_cycles=3.
- Watchdog: MEM_TIMEOUT=4, mem_ready held 0 -> timeout_err=1 after the 4th wait edge, and all enables stay 0 after mem_ready=1. rst pulse -> timeout_err=0, stall_cycles=0.
- Fetch wait: imem_ready=0 for 2 cycles -> pc_write=0, ifid_write=1, ifid_flush=1, idex_flush=0 in both cycles.
- Counter wrap: CNT_WIDTH=4 and 17 single-cycle redirects -> redirect_count=1.
